// File: rtl/teclado_pkg.sv
// teclado_pkg: shared types and constants for the keypad contact emulator.
package teclado_pkg;
  typedef enum logic [3:0] {
    COL0 = 4'b0111,
    COL1 = 4'b1011,
    COL2 = 4'b1101,
    COL3 = 4'b1110
  } col_e;
  typedef enum logic [1:0] {
    IDLE,
    PRESS_BOUNCE,
    HOLD,
    RELEASE_BOUNCE
  } state_e;
  localparam logic [3:0] ROW_IDLE = 4'b1111;
endpackage

// File: rtl/teclado_emulador_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded 8'hA5, free-running.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr_o
);
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr_o <= 8'hA5;
    else lfsr_o <= {lfsr_o[6:0], lfsr_o[7] ^ lfsr_o[5] ^ lfsr_o[4] ^ lfsr_o[3]};
endmodule

// File: rtl/teclado_emulador.sv
// teclado_emulador: emulates one matrix-keypad press with bounce, hold and release phases.
// Define TECLADO_BOUNCE_EMU_EN to make the contact chatter pseudo-randomly inside the bounce windows.
module teclado_emulador
  import teclado_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 600,
  parameter int unsigned BOUNCE_CYCLES = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] key_code,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       busy,
  output logic       done
);
  localparam logic [15:0] B = 16'(BOUNCE_CYCLES);
  localparam logic [15:0] H = 16'(HOLD_CYCLES);
  // Zero-length phases are skipped by jumping straight to the next non-empty one.
  localparam state_e AFTER_HOLD = (B != 16'd0) ? RELEASE_BOUNCE : IDLE;
  localparam state_e AFTER_PB   = (H != 16'd0) ? HOLD : AFTER_HOLD;
  localparam state_e AFTER_IDLE = (B != 16'd0) ? PRESS_BOUNCE : AFTER_PB;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  key_q, key_d;
  logic        contact_q, contact_d, busy_q, done_q, done_d, pb_c, rb_c;
`ifdef TECLADO_BOUNCE_EMU_EN
  logic [7:0] lfsr;
  logic       last_b;
  lfsr8 u_lfsr (.clk(clk), .rst(rst), .lfsr_o(lfsr));
  assign last_b = cnt_d == B - 16'd1;
  assign pb_c   = last_b | lfsr[0];
  assign rb_c   = ~last_b & lfsr[0];
`else
  assign pb_c = 1'b0;
  assign rb_c = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    key_d   = key_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (start) begin
          key_d   = key_code;
          state_d = AFTER_IDLE;
          done_d  = AFTER_IDLE == IDLE;
        end
      end
      PRESS_BOUNCE: if (cnt_q == B - 16'd1) begin
        state_d = AFTER_PB;
        cnt_d   = 16'd0;
      end
      HOLD: if (cnt_q == H - 16'd1) begin
        state_d = AFTER_HOLD;
        cnt_d   = 16'd0;
      end
      default: if (cnt_q == B - 16'd1) begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
    if (state_q != IDLE && state_d == IDLE) done_d = 1'b1;
    contact_d = (state_d == HOLD) | (state_d == PRESS_BOUNCE & pb_c) | (state_d == RELEASE_BOUNCE & rb_c);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      key_q     <= 4'd0;
      contact_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      contact_q <= contact_d;
      busy_q    <= state_d != IDLE;
      done_q    <= done_d;
    end
  // Only the latched target column can close the latched row.
  always_comb begin
    row_out = ROW_IDLE;
    if (contact_q && !col_in[2'd3 - key_q[1:0]]) row_out[2'd3 - key_q[3:2]] = 1'b0;
  end
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_teclado_emulador.sv
// tb_teclado_emulador: scoreboard bench for teclado_emulador, clean build, BOUNCE=4, HOLD=10.
module tb_teclado_emulador;
  localparam int B = 4;
  localparam int H = 10;
  typedef struct {
    logic [3:0] row;
    int         act;
    int         first;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [3:0] col_in = 4'hF;
  logic [3:0] row_out;
  logic       busy, done;
  exp_t       sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_done = 0;
  teclado_emulador #(.HOLD_CYCLES(H), .BOUNCE_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .start(start), .key_code(key_code),
    .col_in(col_in), .row_out(row_out), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  initial begin : monitor
    int busy_cnt, act_cnt, first_act;
    logic [3:0] act_val;
    bit mixed, prev_busy, prev_done;
    exp_t e;
    busy_cnt = 0; act_cnt = 0; first_act = 0; act_val = 4'hF;
    mixed = 0; prev_busy = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        busy_cnt = 0; act_cnt = 0; first_act = 0; act_val = 4'hF;
        mixed = 0; prev_busy = 0; prev_done = 0;
      end else begin
        if (done) begin
          n_done++;
          chk("done_width", int'(prev_done), 0);
          chk("done_expected", int'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("done_after_busy", int'(prev_busy), 1);
            chk("busy_cycles", busy_cnt, 2 * B + H);
            chk("active_cycles", act_cnt, e.act);
            chk("first_active", first_act, e.first);
            chk("row_value", act_val, e.row);
            chk("row_steady", int'(mixed), 0);
          end
          busy_cnt = 0; act_cnt = 0; first_act = 0; act_val = 4'hF; mixed = 0;
        end
        if (busy) begin
          if (row_out != 4'hF) begin
            if (act_cnt == 0) begin
              first_act = busy_cnt;
              act_val = row_out;
            end else if (row_out != act_val) mixed = 1;
            act_cnt++;
          end
          busy_cnt++;
        end else if (row_out != 4'hF) chk("idle_row", row_out, 15);
        prev_busy = busy;
        prev_done = done;
      end
    end
  end
  task automatic press(input logic [3:0] k, input logic [3:0] c, input logic [3:0] er,
                       input int ea, input bit interfere);
    exp_t e;
    bit got;
    e.row = er; e.act = ea; e.first = (ea != 0) ? B : 0;
    sb.push_back(e);
    key_code = k; col_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (interfere && i == 8) begin
        start = 1'b1;
        key_code = 4'b1010;
      end
      if (interfere && i == 9) start = 1'b0;
      @(negedge clk);
      got = done;
    end
    chk("done_seen", int'(got), 1);
  endtask
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin : stim
    int d0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_row", row_out, 15);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    press(4'b0101, 4'b1011, 4'b1011, H + B, 0);
    press(4'b0101, 4'b0111, 4'b1111, 0, 0);
    press(4'b0101, 4'b1011, 4'b1011, H + B, 1);
    press(4'b1111, 4'b1010, 4'b1110, H + B, 0);
    press(4'b0000, 4'b0000, 4'b0111, H + B, 0);
    key_code = 4'b0101; col_in = 4'b1011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_row", row_out, 15);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    d0 = n_done;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);
    press(4'b1010, 4'b1101, 4'b1101, H + B, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", int'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
